// File: rtl/sram_rw_port_ctrl_pkg.sv
// Shared types and sizing helpers for the 1RW SRAM port controller.
// Imported by the controller top; req_t matches the default 8x28 / 14-bit-lane sizing.
package sram_rw_pkg;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    function automatic int unsigned calc_mask_w(input int unsigned data_w,
                                                input int unsigned gran);
        return data_w / gran;
    endfunction

    localparam int unsigned DefAddrW = 3;
    localparam int unsigned DefDataW = 28;
    localparam int unsigned DefMaskW = calc_mask_w(28, 14);

    typedef struct packed {
        logic                write;
        logic [DefAddrW-1:0] addr;
        logic [DefMaskW-1:0] mask;
        logic [DefDataW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response channels between pipeline logic and the SRAM port controller.
interface sram_rw_port_ctrl_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 28,
    parameter int unsigned MASK_W = 2
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [MASK_W-1:0] req_mask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_mask, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_mask, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_rw_port_ctrl_resp_fifo.sv
// Small synchronous FIFO holding captured read data until the consumer takes it.
module sram_rw_resp_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 28
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

    assign pop_data = mem_q[rptr_q];
    assign count    = count_q;
endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Client-side driver for a 1RW masked SRAM macro with in-order read response channel.
// Optional SRAM_RW_INIT_EN: zero-fill the whole array after reset before accepting requests.
module sram_rw_port_ctrl
    import sram_rw_pkg::*;
#(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned DATA_W     = 28,
    parameter int unsigned MASK_GRAN  = 14,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    sram_rw_port_ctrl_if.slave                       bus,
    output logic                                     mem_en,
    output logic                                     mem_wmode,
    output logic [ADDR_W-1:0]                        mem_addr,
    output logic [calc_mask_w(DATA_W, MASK_GRAN)-1:0] mem_wmask,
    output logic [DATA_W-1:0]                        mem_wdata,
    input  logic [DATA_W-1:0]                        mem_rdata,
    output logic                                     init_done
);
    localparam int unsigned MASK_W = calc_mask_w(DATA_W, MASK_GRAN);
    localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    state_e            state_q;
    logic              rd_inflight_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_rdata;
    logic              run, fire, pop, init_active;

`ifdef SRAM_RW_INIT_EN
    logic [ADDR_W-1:0] init_cnt_q;
`endif

    assign run  = reset_n && (state_q == StRun);
    assign pop  = bus.resp_valid && bus.resp_ready;
    assign fire = bus.req_valid && bus.req_ready;

    // Reads in flight plus buffered data may not exceed the FIFO; a same-cycle pop frees a slot.
    assign bus.req_ready = run && (({1'b0, fifo_count} + SUM_W'(rd_inflight_q)) <
                                   (SUM_W'(RESP_DEPTH) + SUM_W'(pop)));
    assign bus.resp_valid = reset_n && (fifo_count != '0);
    assign bus.resp_rdata = fifo_rdata;
    assign init_done      = run;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_inflight_q <= 1'b0;
`ifdef SRAM_RW_INIT_EN
            state_q    <= StInit;
            init_cnt_q <= '0;
`else
            state_q <= StRun;
`endif
        end else begin
            rd_inflight_q <= fire && !bus.req_write;
`ifdef SRAM_RW_INIT_EN
            if (state_q == StInit) begin
                init_cnt_q <= init_cnt_q + 1'b1;
                if (&init_cnt_q) state_q <= StRun;
            end
`endif
        end
    end

`ifdef SRAM_RW_INIT_EN
    assign init_active = reset_n && (state_q == StInit);
`else
    assign init_active = 1'b0;
`endif

    always_comb begin
        mem_en    = fire;
        mem_wmode = bus.req_write;
        mem_addr  = bus.req_addr;
        mem_wmask = bus.req_write ? bus.req_mask : '0;
        mem_wdata = bus.req_wdata;
`ifdef SRAM_RW_INIT_EN
        if (init_active) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = init_cnt_q;
            mem_wmask = '1;
            mem_wdata = '0;
        end
`else
        if (init_active) mem_en = 1'b1;
`endif
    end

    sram_rw_resp_fifo #(
        .DEPTH  (RESP_DEPTH),
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rd_inflight_q),
        .push_data (mem_rdata),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count)
    );

    logic unused_mask_w;
    assign unused_mask_w = ^MASK_W;
endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Scoreboard bench for sram_rw_port_ctrl: behavioural macro + reference model, per-cycle monitor.
module tb_sram_rw_port_ctrl;
    localparam int AW = 3, DW = 28, G = 14, MW = 2, RD = 2, DEPTH = 8;
`ifdef SRAM_RW_INIT_EN
    localparam bit InitEn = 1'b1;
`else
    localparam bit InitEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sram_rw_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

    logic          mem_en, mem_wmode, init_done;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wmask;
    logic [DW-1:0] mem_wdata, mem_rdata;

    sram_rw_port_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .MASK_GRAN(G), .RESP_DEPTH(RD)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_wmode (mem_wmode),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .init_done (init_done)
    );

    // Behavioural SRAM macro: registered read, lane-masked write.
    logic [DW-1:0] macro [DEPTH];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) begin
                for (int l = 0; l < MW; l++)
                    if (mem_wmask[l]) macro[mem_addr][l*G +: G] <= mem_wdata[l*G +: G];
            end else begin
                mem_rdata <= macro[mem_addr];
            end
        end
    end

    typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            cyc = 0, checks = 0, errors = 0, init_left = 0;
    bit            strict_lat = 1'b0, held = 1'b0;
    logic [DW-1:0] held_data;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    bit   ev, er, fr;
    exp_t e;
    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_req_ready", 32'(bus.req_ready), 0);
            chk("rst_resp_valid", 32'(bus.resp_valid), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_init_done", 32'(init_done), 0);
            sb.delete();
            held      = 1'b0;
            init_left = InitEn ? DEPTH : 0;
            if (InitEn) foreach (ref_mem[i]) ref_mem[i] = '0;
        end else begin
            ev = (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);
            er = (init_left == 0) && ((sb.size() < RD) || (ev && bus.resp_ready));
            chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            chk("init_done", 32'(init_done), 32'(init_left == 0));
            fr = bus.req_valid && bus.req_ready;
            if (init_left > 0) begin
                chk("init_mem_en", 32'(mem_en), 1);
                chk("init_wmode", 32'(mem_wmode), 1);
                chk("init_addr", 32'(mem_addr), 32'(DEPTH - init_left));
                chk("init_wmask", 32'(mem_wmask), 32'(2'b11));
                chk("init_wdata", 32'(mem_wdata), 0);
                init_left--;
            end else if (fr) begin
                chk("mem_en", 32'(mem_en), 1);
                chk("mem_wmode", 32'(mem_wmode), 32'(bus.req_write));
                chk("mem_addr", 32'(mem_addr), 32'(bus.req_addr));
                chk("mem_wmask", 32'(mem_wmask), bus.req_write ? 32'(bus.req_mask) : 0);
                if (bus.req_write) chk("mem_wdata", 32'(mem_wdata), 32'(bus.req_wdata));
            end else begin
                chk("mem_en_idle", 32'(mem_en), 0);
            end
            if (held) begin
                chk("hold_valid", 32'(bus.resp_valid), 1);
                chk("hold_data", 32'(bus.resp_rdata), 32'(held_data));
            end
            held      = bus.resp_valid && !bus.resp_ready;
            held_data = bus.resp_rdata;
            if (bus.resp_valid && bus.resp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_resp: got data %0h expected no response", bus.resp_rdata);
                end else begin
                    e = sb.pop_front();
                    chk("resp_data", 32'(bus.resp_rdata), 32'(e.data));
                    if (strict_lat) chk("resp_latency", 32'(cyc - e.cyc), 2);
                    else chk("resp_latency_min", 32'(cyc - e.cyc >= 2), 1);
                end
            end
            if (fr) begin
                if (bus.req_write) begin
                    for (int l = 0; l < MW; l++)
                        if (bus.req_mask[l])
                            ref_mem[bus.req_addr][l*G +: G] = bus.req_wdata[l*G +: G];
                end else begin
                    sb.push_back('{data: ref_mem[bus.req_addr], cyc: cyc});
                end
            end
        end
    end

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [MW-1:0] m,
                         input logic [DW-1:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_mask  = m;
        bus.req_wdata = d;
        forever begin
            @(negedge clock);
            if (bus.req_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: got req_ready 0 expected 1 within 100 cycles");
                break;
            end
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.resp_ready = 1'b1;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    int acc;
    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_mask   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        foreach (macro[i]) macro[i] = DW'($urandom);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

`ifdef SRAM_RW_INIT_EN
        bus.resp_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), 2'b00, '0);
        drain();
`endif
        for (int a = 0; a < DEPTH; a++) issue(1'b1, AW'(a), 2'b11, DW'($urandom));

        strict_lat     = 1'b1;
        bus.resp_ready = 1'b1;
        issue(1'b1, 3'd3, 2'b11, 28'h0ABCDEF);
        issue(1'b0, 3'd3, 2'b00, '0);
        drain();
        issue(1'b1, 3'd5, 2'b11, 28'hFFFFFFF);
        issue(1'b1, 3'd5, 2'b01, 28'h0000000);
        issue(1'b0, 3'd5, 2'b00, '0);
        drain();
        for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), 2'b00, '0);
        drain();
        strict_lat = 1'b0;

        // Backpressure: only RESP_DEPTH reads may be accepted.
        bus.resp_ready = 1'b0;
        acc            = 0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 3'd6;
        repeat (6) begin
            @(negedge clock);
            if (bus.req_ready) acc++;
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        chk("bp_accepted", 32'(acc), RD);
        repeat (3) @(posedge clock);
        #1;
        drain();
        issue(1'b0, 3'd1, 2'b00, '0);
        drain();

        // Reset one cycle after a read fires: the read must vanish.
        issue(1'b0, 3'd2, 2'b00, '0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (DEPTH + 4) @(posedge clock);
        #1;
        issue(1'b0, 3'd2, 2'b00, '0);
        drain();

        for (int i = 0; i < 400; i++) begin
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.req_valid  = ($urandom_range(0, 2) != 0);
            bus.req_write  = $urandom_range(0, 1) == 1;
            bus.req_addr   = AW'($urandom);
            bus.req_mask   = MW'($urandom);
            bus.req_wdata  = DW'($urandom);
            @(posedge clock);
            #1;
        end
        bus.req_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
